decode_stage_pipe: RTL

Registered RV32I instruction-decode stage with valid/ready handshake on both sides. It replaces the flat field splitter with a pipelined decoder that extracts all fields, generates the sign-extended immediate for every format, and classifies format and legality. A 2-entry skid buffer gives full throughput under backpressure. It sits between fetch and register-file read/execute.

---
 rtl/decode_stage_pipe_if.sv | 39 +++
 rtl/decode_stage_pipe.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-decode and decode-to-consumer handshake bundle for decode_stage_pipe.
// Signal names follow the stage's port list; slave is the stage, master is its environment.
interface decode_stage_pipe_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm;
   logic [2:0]      fmt;
   logic            rd_we;
   logic            rs1_used;
   logic            rs2_used;
   logic            illegal;

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
             imm, fmt, rd_we, rs1_used, rs2_used, illegal
   );

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, opcode, funct3, funct7, rs1, rs2, rd,
             imm, fmt, rd_we, rs1_used, rs2_used, illegal
   );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: combinational field/immediate/format decode written into a
// 2-entry skid buffer (head register drives outputs, skid register absorbs backpressure).
module decode_stage_pipe #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned PC_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   decode_stage_pipe_if.slave    bus
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            rd_we;
      logic            rs1_used;
      logic            rs2_used;
      logic            illegal;
   } dec_t;

   dec_t        dec_c;
   dec_t        head_q, head_d;
   dec_t        skid_q, skid_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] ins_c;
   logic [31:0] imm32_c;
   logic        acc_c;
   logic        ret_c;

   assign ins_c = bus.in_instr;

   // Decode of the offered instruction; only captured on accept.
   always_comb begin
      dec_c        = '0;
      imm32_c      = '0;
      dec_c.pc     = bus.in_pc;
      dec_c.opcode = ins_c[6:0];
      dec_c.funct3 = ins_c[14:12];
      dec_c.funct7 = ins_c[31:25];
      dec_c.rs1    = ins_c[19:15];
      dec_c.rs2    = ins_c[24:20];
      dec_c.rd     = ins_c[11:7];

      case (ins_c[6:0])
         7'b0110011:                         dec_c.fmt = FMT_R;
         7'b0010011, 7'b0000011, 7'b1100111,
         7'b0001111, 7'b1110011:             dec_c.fmt = FMT_I;
         7'b0100011:                         dec_c.fmt = FMT_S;
         7'b1100011:                         dec_c.fmt = FMT_B;
         7'b0110111, 7'b0010111:             dec_c.fmt = FMT_U;
         7'b1101111:                         dec_c.fmt = FMT_J;
         default:                            dec_c.fmt = FMT_ILL;
      endcase

      case (dec_c.fmt)
         FMT_I:   imm32_c = {{20{ins_c[31]}}, ins_c[31:20]};
         FMT_S:   imm32_c = {{20{ins_c[31]}}, ins_c[31:25], ins_c[11:7]};
         FMT_B:   imm32_c = {{19{ins_c[31]}}, ins_c[31], ins_c[7], ins_c[30:25],
                             ins_c[11:8], 1'b0};
         FMT_U:   imm32_c = {ins_c[31:12], 12'b0};
         FMT_J:   imm32_c = {{11{ins_c[31]}}, ins_c[31], ins_c[19:12], ins_c[20],
                             ins_c[30:21], 1'b0};
         default: imm32_c = '0;
      endcase
      dec_c.imm = XLEN'($signed(imm32_c));

      dec_c.rd_we    = ((dec_c.fmt == FMT_R) || (dec_c.fmt == FMT_I) ||
                        (dec_c.fmt == FMT_U) || (dec_c.fmt == FMT_J)) &&
                       (dec_c.rd != 5'd0);
      dec_c.rs1_used = (dec_c.fmt == FMT_R) || (dec_c.fmt == FMT_I) ||
                       (dec_c.fmt == FMT_S) || (dec_c.fmt == FMT_B);
      dec_c.rs2_used = (dec_c.fmt == FMT_R) || (dec_c.fmt == FMT_S) ||
                       (dec_c.fmt == FMT_B);
      dec_c.illegal  = (dec_c.fmt == FMT_ILL);
   end

   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign acc_c         = bus.in_valid && (count_q != 2'd2);
   assign ret_c         = bus.out_ready && (count_q != 2'd0);

   // Buffer update; head holds its value when emptied so outputs stay stable.
   always_comb begin
      head_d  = head_q;
      skid_d  = skid_q;
      count_d = count_q;
      if (bus.flush) begin
         count_d = 2'd0;
      end else begin
         case (count_q)
            2'd0: begin
               if (acc_c) begin
                  head_d  = dec_c;
                  count_d = 2'd1;
               end
            end
            2'd1: begin
               case ({acc_c, ret_c})
                  2'b10: begin
                     skid_d  = dec_c;
                     count_d = 2'd2;
                  end
                  2'b01:   count_d = 2'd0;
                  2'b11:   head_d  = dec_c;
                  default: ;
               endcase
            end
            2'd2: begin
               if (ret_c) begin
                  head_d  = skid_q;
                  count_d = 2'd1;
               end
            end
            default: count_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         skid_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         skid_q  <= skid_d;
         count_q <= count_d;
      end
   end

   assign bus.out_pc   = head_q.pc;
   assign bus.opcode   = head_q.opcode;
   assign bus.funct3   = head_q.funct3;
   assign bus.funct7   = head_q.funct7;
   assign bus.rs1      = head_q.rs1;
   assign bus.rs2      = head_q.rs2;
   assign bus.rd       = head_q.rd;
   assign bus.imm      = head_q.imm;
   assign bus.fmt      = head_q.fmt;
   assign bus.rd_we    = head_q.rd_we;
   assign bus.rs1_used = head_q.rs1_used;
   assign bus.rs2_used = head_q.rs2_used;
   assign bus.illegal  = head_q.illegal;

endmodule
